// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow
//   flip-flop, LSB first, one bit per clock. A result takes WIDTH RUN
//   cycles, followed by a single DONE cycle.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow
//   output ovf. Without the macro, that port and its logic are absent.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request; accepted in IDLE or DONE, ignored in RUN
//   a, b        minuend / subtrahend, captured on the accepting edge
//   busy        high in RUN
//   done        one-cycle pulse in DONE; results are valid
//   diff        registered a-b mod 2^WIDTH
//   borrow_out  final borrow (a < b unsigned)
//   ovf         signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, wd_q, wd_d, diff_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, bo_q;
  logic             d_bit, bnext, accept, last;

  // Full-subtractor cell on the operand LSBs.
  assign d_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign bnext = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  // start is honoured in IDLE and DONE (back-to-back), never in RUN.
  assign accept = start && (state_q != S_RUN);
  assign last   = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));
  assign wd_d   = {d_bit, wd_q[WIDTH-1:1]};
  assign cnt_d  = cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Datapath: operand shifters, borrow FF, counter, working/result regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      wd_q   <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bo_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      wd_q  <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      wd_q  <= wd_d;
      cnt_q <= cnt_d;
      br_q  <= bnext;
      if (last) begin
        diff_q <= wd_d;
        bo_q   <= bnext;
      end
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bo_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out during RUN, so keep copies for the flag.
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (last) begin
      // d_bit is the result MSB on the completion edge.
      ovf_q <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] a, b, diff;
  logic         busy, done, borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  function automatic logic [W-1:0] sub_of(input logic [W-1:0] x, input logic [W-1:0] y);
    return x - y;
  endfunction

  function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = x - y;
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Reference model: an accepted op keeps the unit busy for W cycles, then
  // exposes its arithmetic result for one done cycle and holds it after.
  int           m_left;
  bit           m_done, m_bo, m_ovf, p_bo, p_ovf;
  logic [W-1:0] m_diff, p_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_done <= 0; m_diff <= '0; m_bo <= 0; m_ovf <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_diff <= p_diff; m_bo <= p_bo; m_ovf <= p_ovf;
      end
    end else begin
      m_done <= 0;
      if (start) begin
        p_diff <= sub_of(a, b);
        p_bo   <= (a < b);
        p_ovf  <= ovf_of(a, b);
        m_left <= W;
      end
    end
  end

  // Compare DUT against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("diff", diff, m_diff);
      chk("borrow_out", borrow_out, m_bo);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", ovf, m_ovf);
`endif
      if (busy && done) chk("busy_and_done", 1, 0);
    end
  end

  // One operation from idle with literal expectations and latency check.
  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                    input logic [W-1:0] ed, input logic eb, input logic eo,
                    input string nm);
    int n, bc;
    @(negedge clk); a = aa; b = bb; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk); n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_busy_cycles"}, bc, W);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_borrow"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) chk({nm, "_ovf_arg"}, eo, 0);
`endif
  endtask

  initial begin
    int dcnt, last_t, cyc;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_borrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub_5_3");
    op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_3_5");
    op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "sub_ff_ff");
    op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "sub_0_1");
    op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");
    op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "sub_7f_ff");

    // Re-pulse start on the 3rd RUN cycle: must be ignored.
    @(negedge clk); a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'h00; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin dcnt++; chk("ignore_start_diff", diff, 8'h0F); end
      @(negedge clk);
    end
    chk("ignore_start_done_pulses", dcnt, 1);

    // start held high: back-to-back, one result every W+1 cycles.
    a = 8'h09; b = 8'h04; start = 1'b1;
    last_t = -1; dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        chk("b2b_diff", diff, 8'h05);
        if (last_t >= 0) chk("b2b_period", i - last_t, 9);
        last_t = i;
      end
    end
    chk("b2b_count_ge3", dcnt >= 3, 1);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during the 4th RUN cycle.
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_run_busy", busy, 0);
    chk("rst_run_done", done, 0);
    chk("rst_run_diff", diff, 0);
    chk("rst_run_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_run_ovf", ovf, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    op(8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, "sub_0a_0a");

    // Random traffic, checked by the model every cycle.
    cyc = 0;
    while (cyc < 600) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      cyc++;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on rising edge of clk.
REQ-005 Port: a  input  WIDTH  minuend; captured only on the edge that accepts start.
REQ-006 Port: b  input  WIDTH  subtrahend; captured only on the edge that accepts start.
REQ-007 Port: busy  output  1  high while bits are being processed (RUN state).
REQ-008 Port: done  output  1  one-cycle pulse; diff and borrow_out are valid for the new operation.
REQ-009 Port: diff  output  WIDTH  registered result a-b modulo 2^WIDTH.
REQ-010 Port: borrow_out  output  1  final borrow; 1 iff unsigned a < b.
REQ-011 Port: ovf  output  1  signed overflow flag; present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-012 Datapath is one full-subtractor bit cell plus a borrow flip-flop; processing is LSB-first, one bit per cycle.
REQ-013 Bit cell: d = ai ^ bi ^ br; bnext = (~ai & bi) | (~(ai ^ bi) & br).
REQ-014 FSM states are IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: start=1 loads a and b into shift registers, clears the borrow FF and the bit counter, and moves to RUN.
REQ-016 RUN: each edge computes one bit from the operand LSBs and the borrow FF, shifts the bit into the MSB of the working diff register, shifts the operands right, updates the borrow FF with bnext, and increments the counter.
REQ-017 RUN: on the WIDTH-th RUN edge, the FSM copies the working register to diff and the final bnext to borrow_out, then moves to DONE.
REQ-018 DONE lasts exactly one cycle, with done=1; the FSM then moves to IDLE, or to RUN if start=1 (back-to-back accept, same actions as REQ-015).
REQ-019 Latency: done is high in the cycle after the WIDTH-th edge following the accepting edge, i.e. WIDTH edges after start is accepted.
REQ-020 start is ignored while in RUN; the in-flight operation is unaffected and a, b are not re-sampled.
REQ-021 diff and borrow_out change only on the completion edge and hold their values through IDLE and the following RUN.
REQ-022 busy is 1 exactly in RUN; done is 1 exactly in DONE; the two are never high together.
REQ-023 Equal operands yield diff=0 and borrow_out=0; a=0 with b=1 yields diff=all-ones and borrow_out=1.

Reset
REQ-024 rst_n=0 immediately forces: state IDLE; busy=0, done=0, diff=0, borrow_out=0, ovf=0; counter, borrow FF and shift registers cleared.
REQ-025 Reset during RUN abandons the operation; no done pulse is issued for it.
REQ-026 The first start is accepted on the first rising edge with rst_n=1 and start=1.

Configuration
REQ-027 With SERIAL_SUB_OVF_EN defined, port ovf exists and is registered on the completion edge as (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands, and is held with diff.
REQ-028 Without SERIAL_SUB_OVF_EN, port ovf and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-029 a=0x05, b=0x03, one start pulse -> done 8 edges after accept; diff=0x02, borrow_out=0, busy high exactly 8 cycles.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
REQ-031 With SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
REQ-032 start re-pulsed with a=0x00, b=0x01 on the 3rd RUN cycle of 0x10-0x01 -> result diff=0x0F; exactly one done pulse.
REQ-033 start held high continuously with a=0x09, b=0x04 -> back-to-back operations; done every 9 cycles, diff=0x05 each time.
REQ-034 rst_n pulsed low during the 4th RUN cycle -> all outputs 0 immediately, no done pulse; next start with 0x0A-0x0A -> diff=0x00, borrow_out=0.
